// File: rtl/axis_stream_stat.sv
// rtl/axis_stream_stat.sv - AXI-stream test sink with programmable backpressure and per-channel statistics
module axis_stream_stat #(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 16,
  parameter  int SAT   = 0,
  parameter  int GAP   = 0,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             axis_tvalid,
  output logic             axis_tready,
  input  logic             axis_tlast,
  input  logic [CH_W-1:0]  axis_tuser,
  input  logic             enable,
  input  logic             clear,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_beat,
  output logic [CNT_W-1:0] rd_pkt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             pkt_err,
  output logic [CH_W-1:0]  err_ch
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } state_t;

  logic                       gap_hit;
  logic                       fire;

  logic [NCH-1:0][CNT_W-1:0]  beat_q, beat_d;
  logic [NCH-1:0][CNT_W-1:0]  pkt_q, pkt_d;
  logic [CNT_W-1:0]           stall_q, stall_d;
  state_t                     state_q, state_d;
  logic [CH_W-1:0]            cur_ch_q, cur_ch_d;
  logic                       pkt_err_q, pkt_err_d;
  logic [CH_W-1:0]            err_ch_q, err_ch_d;
  logic [CNT_W-1:0]           rd_beat_q, rd_pkt_q;

  // Counter step: wraps naturally, or holds at all-ones when saturating.
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    if ((SAT != 0) && (&v)) return v;
    return v + 1'b1;
  endfunction

  if (GAP > 0) begin : g_gap
    logic [GAP_W-1:0] gap_q, gap_d;

    // Gap counter advances only while enabled, wrapping after GAP.
    always_comb begin
      gap_d = gap_q;
      if (enable) gap_d = (gap_q == GAP_W'(GAP)) ? '0 : gap_q + 1'b1;
    end

    // Gap counter register; untouched by clear.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) gap_q <= '0;
      else        gap_q <= gap_d;
    end

    assign gap_hit = (gap_q == GAP_W'(GAP));
  end else begin : g_nogap
    assign gap_hit = 1'b0;
  end

  // Ready is held low through reset so nothing is accepted before the block is live.
  assign axis_tready = rst_n & enable & ~gap_hit;
  assign fire        = axis_tvalid & axis_tready;

  // Next-state for counters, packet FSM and interleave error; clear overrides everything.
  always_comb begin
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    stall_d   = stall_q;
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    pkt_err_d = pkt_err_q;
    err_ch_d  = err_ch_q;
    if (clear) begin
      beat_d    = '0;
      pkt_d     = '0;
      stall_d   = '0;
      state_d   = S_IDLE;
      cur_ch_d  = '0;
      pkt_err_d = 1'b0;
      err_ch_d  = '0;
    end else begin
      if (axis_tvalid && !axis_tready) stall_d = inc(stall_q);
      if (fire) begin
        beat_d[axis_tuser] = inc(beat_q[axis_tuser]);
        if (axis_tlast) pkt_d[axis_tuser] = inc(pkt_q[axis_tuser]);
        case (state_q)
          S_IDLE: begin
            if (!axis_tlast) begin
              state_d  = S_IN_PKT;
              cur_ch_d = axis_tuser;
            end
          end
          S_IN_PKT: begin
            if (axis_tuser != cur_ch_q) begin
              pkt_err_d = 1'b1;
              if (!pkt_err_q) err_ch_d = axis_tuser;
            end
            if (axis_tlast) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State registers for statistics and packet tracking.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      pkt_q     <= '0;
      stall_q   <= '0;
      state_q   <= S_IDLE;
      cur_ch_q  <= '0;
      pkt_err_q <= 1'b0;
      err_ch_q  <= '0;
    end else begin
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
      stall_q   <= stall_d;
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      pkt_err_q <= pkt_err_d;
      err_ch_q  <= err_ch_d;
    end
  end

  // Registered readout of the selected channel, sampled every cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_beat_q <= '0;
      rd_pkt_q  <= '0;
    end else begin
      rd_beat_q <= beat_q[rd_ch];
      rd_pkt_q  <= pkt_q[rd_ch];
    end
  end

  assign rd_beat   = rd_beat_q;
  assign rd_pkt    = rd_pkt_q;
  assign stall_cnt = stall_q;
  assign pkt_err   = pkt_err_q;
  assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_axis_stream_stat.sv
// tb/tb_axis_stream_stat.sv - self-checking bench for axis_stream_stat over four parameter sets
module tb_axis_stream_stat;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic [1:0] tuser = 2'd0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] rd_ch = 2'd0;

  always #5 clk = ~clk;

  // inst 0: plain, inst 1: GAP=3, inst 2: CNT_W=4 wrap, inst 3: CNT_W=4 saturate
  logic        r0, r1, r2, r3;
  logic        e0, e1, e2, e3;
  logic [1:0]  c0, c1, c2, c3;
  logic [15:0] b0, p0, s0, b1, p1, s1;
  logic [3:0]  b2, p2, s2, b3, p3, s3;

  axis_stream_stat #(.NCH(4), .CNT_W(16), .SAT(0), .GAP(0)) u_main (
    .clock(clk), .rst_n(rst_n), .axis_tvalid(tvalid), .axis_tready(r0), .axis_tlast(tlast),
    .axis_tuser(tuser), .enable(enable), .clear(clear), .rd_ch(rd_ch),
    .rd_beat(b0), .rd_pkt(p0), .stall_cnt(s0), .pkt_err(e0), .err_ch(c0));

  axis_stream_stat #(.NCH(4), .CNT_W(16), .SAT(0), .GAP(3)) u_gap (
    .clock(clk), .rst_n(rst_n), .axis_tvalid(tvalid), .axis_tready(r1), .axis_tlast(tlast),
    .axis_tuser(tuser), .enable(enable), .clear(clear), .rd_ch(rd_ch),
    .rd_beat(b1), .rd_pkt(p1), .stall_cnt(s1), .pkt_err(e1), .err_ch(c1));

  axis_stream_stat #(.NCH(4), .CNT_W(4), .SAT(0), .GAP(0)) u_wrap (
    .clock(clk), .rst_n(rst_n), .axis_tvalid(tvalid), .axis_tready(r2), .axis_tlast(tlast),
    .axis_tuser(tuser), .enable(enable), .clear(clear), .rd_ch(rd_ch),
    .rd_beat(b2), .rd_pkt(p2), .stall_cnt(s2), .pkt_err(e2), .err_ch(c2));

  axis_stream_stat #(.NCH(4), .CNT_W(4), .SAT(1), .GAP(0)) u_sat (
    .clock(clk), .rst_n(rst_n), .axis_tvalid(tvalid), .axis_tready(r3), .axis_tlast(tlast),
    .axis_tuser(tuser), .enable(enable), .clear(clear), .rd_ch(rd_ch),
    .rd_beat(b3), .rd_pkt(p3), .stall_cnt(s3), .pkt_err(e3), .err_ch(c3));

  int total = 0;
  int bad   = 0;

  int P_GAP [4] = '{0, 3, 0, 0};
  int P_W   [4] = '{16, 16, 4, 4};
  int P_SAT [4] = '{0, 0, 0, 1};

  int m_beat [4][4];
  int m_pkt  [4][4];
  int m_stall[4];
  int m_err  [4];
  int m_errch[4];
  int m_in   [4];
  int m_cur  [4];
  int m_en   [4];
  int m_rdb  [4];
  int m_rdp  [4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bump(input int v, input int w, input int sat);
    int mx;
    mx = (1 << w) - 1;
    if (v == mx) return (sat != 0) ? v : 0;
    return v + 1;
  endfunction

  // Ready derives from how many enabled cycles have elapsed since reset.
  function automatic int exp_rdy(input int i);
    if (!rst_n || !enable) return 0;
    if (P_GAP[i] == 0) return 1;
    return ((m_en[i] % (P_GAP[i] + 1)) == P_GAP[i]) ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        m_beat[i][c] = 0;
        m_pkt[i][c]  = 0;
      end
      m_stall[i] = 0; m_err[i] = 0; m_errch[i] = 0; m_in[i] = 0;
      m_cur[i] = 0; m_en[i] = 0; m_rdb[i] = 0; m_rdp[i] = 0;
    end
  endtask

  // Reference model: advances on every clock edge or reset assertion.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int i = 0; i < 4; i++) begin
          int rdy;
          int ch;
          rdy = exp_rdy(i);
          ch  = int'(tuser);
          m_rdb[i] = m_beat[i][rd_ch];
          m_rdp[i] = m_pkt[i][rd_ch];
          if (clear) begin
            for (int c = 0; c < 4; c++) begin
              m_beat[i][c] = 0;
              m_pkt[i][c]  = 0;
            end
            m_stall[i] = 0; m_err[i] = 0; m_errch[i] = 0; m_in[i] = 0;
          end else begin
            if (tvalid && rdy == 0) m_stall[i] = bump(m_stall[i], P_W[i], P_SAT[i]);
            if (tvalid && rdy == 1) begin
              m_beat[i][ch] = bump(m_beat[i][ch], P_W[i], P_SAT[i]);
              if (tlast) m_pkt[i][ch] = bump(m_pkt[i][ch], P_W[i], P_SAT[i]);
              if (m_in[i] != 0 && ch != m_cur[i]) begin
                if (m_err[i] == 0) m_errch[i] = ch;
                m_err[i] = 1;
              end
              if (tlast) m_in[i] = 0;
              else if (m_in[i] == 0) begin
                m_in[i]  = 1;
                m_cur[i] = ch;
              end
            end
          end
          if (enable) m_en[i]++;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input int rdy, input int rb, input int rp,
                          input int st, input int er, input int ec);
    chk($sformatf("tready[%0d]", i),    rdy, exp_rdy(i));
    chk($sformatf("rd_beat[%0d]", i),   rb,  m_rdb[i]);
    chk($sformatf("rd_pkt[%0d]", i),    rp,  m_rdp[i]);
    chk($sformatf("stall_cnt[%0d]", i), st,  m_stall[i]);
    chk($sformatf("pkt_err[%0d]", i),   er,  m_err[i]);
    chk($sformatf("err_ch[%0d]", i),    ec,  m_errch[i]);
  endtask

  // Every falling edge, all four instances are checked against the model.
  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, int'(r0), int'(b0), int'(p0), int'(s0), int'(e0), int'(c0));
      cmp_inst(1, int'(r1), int'(b1), int'(p1), int'(s1), int'(e1), int'(c1));
      cmp_inst(2, int'(r2), int'(b2), int'(p2), int'(s2), int'(e2), int'(c2));
      cmp_inst(3, int'(r3), int'(b3), int'(p3), int'(s3), int'(e3), int'(c3));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input bit last);
    tvalid = 1'b1;
    tuser  = 2'(ch);
    tlast  = last;
    cyc();
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic do_clear();
    tvalid = 1'b0;
    clear  = 1'b1;
    cyc();
    clear  = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    repeat (3) cyc();
    chk("lit reset tready", int'(r0), 0);
    chk("lit reset rd_beat", int'(b0), 0);
    rst_n = 1'b1;
    cyc();

    // Backpressure pattern: 40 cycles of valid single-beat packets on ch0.
    enable = 1'b1;
    repeat (40) send(0, 1'b1);
    idle(2);
    chk("lit gap stall_cnt", int'(s1), 10);
    chk("lit gap rd_beat", int'(b1), 30);
    chk("lit main rd_beat", int'(b0), 40);

    // 4-bit counters: 20 single-beat packets.
    do_clear();
    repeat (20) send(0, 1'b1);
    idle(2);
    chk("lit wrap rd_beat", int'(b2), 4);
    chk("lit wrap rd_pkt", int'(p2), 4);
    chk("lit sat rd_beat", int'(b3), 15);
    chk("lit sat rd_pkt", int'(p3), 15);

    // One 5-beat packet per channel, then sweep readout.
    do_clear();
    for (int ch = 0; ch < 4; ch++)
      for (int b = 0; b < 5; b++) send(ch, b == 4);
    idle(1);
    for (int ch = 0; ch < 4; ch++) begin
      rd_ch = 2'(ch);
      cyc();
      chk($sformatf("lit sweep rd_beat ch%0d", ch), int'(b0), 5);
      chk($sformatf("lit sweep rd_pkt ch%0d", ch), int'(p0), 1);
    end
    chk("lit sweep pkt_err", int'(e0), 0);

    // Interleave: ch1 packet broken by ch2, then ch3.
    do_clear();
    send(1, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    chk("lit intlv pkt_err", int'(e0), 1);
    chk("lit intlv err_ch", int'(c0), 2);
    send(3, 1'b0);
    chk("lit intlv err_ch kept", int'(c0), 2);
    send(1, 1'b1);
    rd_ch = 2'd2;
    idle(2);
    chk("lit intlv beat ch2", int'(b0), 1);

    // Clear coincident with a fire at beat[0]=7.
    do_clear();
    rd_ch = 2'd0;
    send(1, 1'b0);
    repeat (7) send(0, 1'b1);
    idle(1);
    chk("lit pre-clear rd_beat", int'(b0), 7);
    chk("lit pre-clear pkt_err", int'(e0), 1);
    tvalid = 1'b1; tuser = 2'd0; tlast = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0;
    tvalid = 1'b0;
    chk("lit clear pkt_err", int'(e0), 0);
    chk("lit clear tready", int'(r0), 1);
    cyc();
    chk("lit clear rd_beat", int'(b0), 0);

    // Reset mid-packet, then a clean 3-beat packet.
    send(2, 1'b0);
    send(2, 1'b0);
    tvalid = 1'b0;
    enable = 1'b0;
    rst_n  = 1'b0;
    cyc();
    chk("lit rst tready en0", int'(r0), 0);
    enable = 1'b1;
    cyc();
    chk("lit rst tready en1", int'(r0), 0);
    chk("lit rst stall_cnt", int'(s0), 0);
    rst_n = 1'b1;
    send(3, 1'b0);
    send(3, 1'b0);
    send(3, 1'b1);
    rd_ch = 2'd3;
    idle(2);
    chk("lit post-rst rd_pkt", int'(p0), 1);
    chk("lit post-rst rd_beat", int'(b0), 3);
    chk("lit post-rst pkt_err", int'(e0), 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
